// File: rtl/mul_rs_sched.sv
// Mul/div reservation-station group: entry allocation, tag handout,
// round-robin result arbitration into a registered CDB output stage.
module mul_rs_sched #(
    parameter int NUM_RS   = 3,
    parameter int TAG_BASE = 4,
    parameter int DATA_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    output logic [3:0]               issue_tag,
    output logic [NUM_RS-1:0]        rs_sel,
    input  logic [NUM_RS-1:0]        rs_done,
    input  logic [NUM_RS*DATA_W-1:0] rs_result,
    output logic [NUM_RS-1:0]        rs_ack,
    output logic                     cdb_valid,
    output logic [3:0]               cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    input  logic                     cdb_ready,
    output logic [3:0]               occupancy
);

    localparam int IW = $clog2(NUM_RS);
    typedef logic [IW-1:0] idx_t;

    localparam logic [NUM_RS-1:0] ONE = {{(NUM_RS-1){1'b0}}, 1'b1};

    logic [NUM_RS-1:0] held_q, held_d;
    idx_t              rr_q, rr_d;
    logic              vld_q, vld_d;
    logic [3:0]        tag_q, tag_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [NUM_RS-1:0] free;
    logic [NUM_RS-1:0] cand;
    idx_t              tgt;
    idx_t              win;
    logic              win_found;
    logic              issue_fire;
    logic              load;
    int                j;

    assign free        = ~held_q;
    assign cand        = rs_done & held_q;
    assign issue_ready = |free;
    assign issue_fire  = issue_valid && issue_ready && !flush;
    assign load        = (!vld_q || cdb_ready) && (|cand) && !flush;

    always_comb begin
        tgt = '0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (free[i]) tgt = idx_t'(i);
        end
    end

    // Scan starts at rr_q and wraps so the last winner goes to the back.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        j         = 0;
        for (int k = 0; k < NUM_RS; k++) begin
            j = int'(rr_q) + k;
            if (j >= NUM_RS) j = j - NUM_RS;
            if (!win_found && cand[j]) begin
                win_found = 1'b1;
                win       = idx_t'(j);
            end
        end
    end

    assign issue_tag = issue_ready ? 4'(TAG_BASE) + 4'(tgt) : 4'd0;
    assign rs_sel    = issue_fire ? (ONE << tgt) : '0;
    assign rs_ack    = load ? (ONE << win) : '0;

    always_comb begin
        held_d = (held_q | rs_sel) & ~rs_ack;
        rr_d   = rr_q;
        vld_d  = vld_q;
        tag_d  = tag_q;
        data_d = data_q;
        if (load) begin
            vld_d  = 1'b1;
            tag_d  = 4'(TAG_BASE) + 4'(win);
            data_d = rs_result[win*DATA_W +: DATA_W];
            rr_d   = (win == idx_t'(NUM_RS - 1)) ? '0 : win + idx_t'(1);
        end else if (cdb_ready) begin
            vld_d = 1'b0;
        end
        if (flush) begin
            held_d = '0;
            vld_d  = 1'b0;
            rr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held_q <= '0;
            rr_q   <= '0;
            vld_q  <= 1'b0;
            tag_q  <= 4'd0;
            data_q <= '0;
        end else begin
            held_q <= held_d;
            rr_q   <= rr_d;
            vld_q  <= vld_d;
            tag_q  <= tag_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        occupancy = 4'd0;
        for (int i = 0; i < NUM_RS; i++) begin
            occupancy = occupancy + {3'b000, held_q[i]};
        end
    end

    assign cdb_valid = vld_q;
    assign cdb_tag   = tag_q;
    assign cdb_data  = data_q;

endmodule

// File: tb/tb_mul_rs_sched.sv
// Directed bench for mul_rs_sched (NUM_RS=3, TAG_BASE=4, DATA_W=32).
// Inputs change on negedge; outputs sampled #1 after negedge or posedge.
module tb_mul_rs_sched;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_tag;
    logic [2:0]  rs_sel;
    logic [2:0]  rs_done;
    logic [95:0] rs_result;
    logic [2:0]  rs_ack;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_ready;
    logic [3:0]  occupancy;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] R0 = 32'h1111_1111;
    localparam logic [31:0] R1 = 32'h2222_2222;
    localparam logic [31:0] R2 = 32'h3333_3333;

    mul_rs_sched #(.NUM_RS(3), .TAG_BASE(4), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_tag  (issue_tag),
        .rs_sel     (rs_sel),
        .rs_done    (rs_done),
        .rs_result  (rs_result),
        .rs_ack     (rs_ack),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .cdb_ready  (cdb_ready),
        .occupancy  (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({issue_ready, issue_tag, rs_sel, rs_ack} !== {1'b1, 4'd4, 3'b000, 3'b000}) begin
            errors++;
            $display("FAIL reset_issue rdy=%b tag=%0d sel=%b ack=%b exp 1/4/000/000",
                     issue_ready, issue_tag, rs_sel, rs_ack);
        end
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, occupancy} !== {1'b0, 4'd0, 32'd0, 4'd0}) begin
            errors++;
            $display("FAIL reset_cdb v=%b tag=%0d data=%h occ=%0d exp 0/0/0/0",
                     cdb_valid, cdb_tag, cdb_data, occupancy);
        end
    endtask

    task automatic test_issue;
        logic [2:0] exp_sel [3];
        exp_sel[0] = 3'b001;
        exp_sel[1] = 3'b010;
        exp_sel[2] = 3'b100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            issue_valid = 1'b1;
            #1;
            checks++;
            if (rs_sel !== exp_sel[i] || issue_tag !== 4'(4 + i)) begin
                errors++;
                $display("FAIL issue%0d sel=%b tag=%0d exp %b/%0d",
                         i, rs_sel, issue_tag, exp_sel[i], 4 + i);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if ({issue_ready, issue_tag, rs_sel, occupancy} !== {1'b0, 4'd0, 3'b000, 4'd3}) begin
            errors++;
            $display("FAIL issue_full rdy=%b tag=%0d sel=%b occ=%0d exp 0/0/000/3",
                     issue_ready, issue_tag, rs_sel, occupancy);
        end
        @(negedge clk);
        issue_valid = 1'b0;
    endtask

    task automatic test_simultaneous;
        logic [2:0]  exp_ack [3];
        logic [31:0] exp_dat [3];
        exp_ack[0] = 3'b001;
        exp_ack[1] = 3'b010;
        exp_ack[2] = 3'b100;
        exp_dat[0] = R0;
        exp_dat[1] = R1;
        exp_dat[2] = R2;
        cdb_ready = 1'b1;
        rs_done = 3'b111;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (rs_ack !== exp_ack[i]) begin
                errors++;
                $display("FAIL simul_ack%0d got %b exp %b", i, rs_ack, exp_ack[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 4'(4 + i), exp_dat[i]}) begin
                errors++;
                $display("FAIL simul_cdb%0d v=%b tag=%0d data=%h exp 1/%0d/%h",
                         i, cdb_valid, cdb_tag, cdb_data, 4 + i, exp_dat[i]);
            end
            @(negedge clk);
        end
        rs_done = 3'b000;
        @(posedge clk);
        #1;
        checks++;
        if (cdb_valid !== 1'b0 || occupancy !== 4'd0) begin
            errors++;
            $display("FAIL simul_drain v=%b occ=%0d exp 0/0", cdb_valid, occupancy);
        end
    endtask

    task automatic test_complete;
        @(negedge clk);
        issue_valid = 1'b1;
        repeat (3) @(negedge clk);
        issue_valid = 1'b0;
        rs_result[63:32] = 32'h0000_00A5;
        rs_done = 3'b010;
        #1;
        checks++;
        if (rs_ack !== 3'b010) begin
            errors++;
            $display("FAIL complete_ack got %b exp 010", rs_ack);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 4'd5, 32'h0000_00A5}) begin
            errors++;
            $display("FAIL complete_cdb v=%b tag=%0d data=%h exp 1/5/000000a5",
                     cdb_valid, cdb_tag, cdb_data);
        end
        checks++;
        if ({issue_ready, issue_tag, occupancy} !== {1'b1, 4'd5, 4'd2}) begin
            errors++;
            $display("FAIL complete_free rdy=%b tag=%0d occ=%0d exp 1/5/2",
                     issue_ready, issue_tag, occupancy);
        end
        @(negedge clk);
        rs_done = 3'b000;
        rs_result[63:32] = R1;
        @(posedge clk);
        #1;
        checks++;
        if (cdb_valid !== 1'b0 || cdb_tag !== 4'd5) begin
            errors++;
            $display("FAIL complete_idle v=%b tag=%0d exp 0/5", cdb_valid, cdb_tag);
        end
        @(negedge clk);
        issue_valid = 1'b1;
        #1;
        checks++;
        if (rs_sel !== 3'b010) begin
            errors++;
            $display("FAIL complete_reissue sel=%b exp 010", rs_sel);
        end
        @(negedge clk);
        issue_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        rs_done = 3'b001;
        #1;
        checks++;
        if (rs_ack !== 3'b001) begin
            errors++;
            $display("FAIL bp_first_ack got %b exp 001", rs_ack);
        end
        @(negedge clk);
        cdb_ready = 1'b0;
        rs_done = 3'b110;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (rs_ack !== 3'b000) begin
                errors++;
                $display("FAIL bp_ack%0d got %b exp 000", i, rs_ack);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 4'd4, R0}) begin
                errors++;
                $display("FAIL bp_hold%0d v=%b tag=%0d data=%h exp 1/4/%h",
                         i, cdb_valid, cdb_tag, cdb_data, R0);
            end
            @(negedge clk);
        end
        cdb_ready = 1'b1;
        #1;
        checks++;
        if (rs_ack !== 3'b010) begin
            errors++;
            $display("FAIL bp_release_ack got %b exp 010", rs_ack);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 4'd5, R1}) begin
            errors++;
            $display("FAIL bp_release_cdb v=%b tag=%0d data=%h exp 1/5/%h",
                     cdb_valid, cdb_tag, cdb_data, R1);
        end
        @(negedge clk);
        rs_done = 3'b000;
        @(posedge clk);
        #1;
        checks++;
        if (cdb_valid !== 1'b0 || occupancy !== 4'd1) begin
            errors++;
            $display("FAIL bp_drain v=%b occ=%0d exp 0/1", cdb_valid, occupancy);
        end
    endtask

    task automatic test_fairness;
        logic [2:0] exp_ack [5];
        logic [2:0] exp_sel [5];
        logic [3:0] exp_tag [5];
        exp_ack = '{3'b100, 3'b001, 3'b100, 3'b001, 3'b100};
        exp_sel = '{3'b000, 3'b100, 3'b001, 3'b100, 3'b001};
        exp_tag = '{4'd6, 4'd4, 4'd6, 4'd4, 4'd6};
        @(negedge clk);
        issue_valid = 1'b1;
        #1;
        checks++;
        if (rs_sel !== 3'b001) begin
            errors++;
            $display("FAIL fair_setup sel=%b exp 001", rs_sel);
        end
        @(negedge clk);
        @(negedge clk);
        rs_done = 3'b101;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (rs_ack !== exp_ack[i] || rs_sel !== exp_sel[i]) begin
                errors++;
                $display("FAIL fair%0d ack=%b sel=%b exp %b/%b",
                         i, rs_ack, rs_sel, exp_ack[i], exp_sel[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (cdb_valid !== 1'b1 || cdb_tag !== exp_tag[i]) begin
                errors++;
                $display("FAIL fair_cdb%0d v=%b tag=%0d exp 1/%0d",
                         i, cdb_valid, cdb_tag, exp_tag[i]);
            end
            @(negedge clk);
        end
        rs_done = 3'b000;
        cdb_ready = 1'b0;
        #1;
        checks++;
        if (rs_sel !== 3'b100) begin
            errors++;
            $display("FAIL fair_fill sel=%b exp 100", rs_sel);
        end
        @(negedge clk);
        issue_valid = 1'b0;
    endtask

    task automatic test_flush;
        checks++;
        if (occupancy !== 4'd3 || cdb_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre occ=%0d v=%b exp 3/1", occupancy, cdb_valid);
        end
        flush = 1'b1;
        issue_valid = 1'b1;
        cdb_ready = 1'b1;
        rs_done = 3'b111;
        #1;
        checks++;
        if (rs_sel !== 3'b000 || rs_ack !== 3'b000) begin
            errors++;
            $display("FAIL flush_comb sel=%b ack=%b exp 000/000", rs_sel, rs_ack);
        end
        @(posedge clk);
        #1;
        checks++;
        if (occupancy !== 4'd0 || cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_state occ=%0d v=%b exp 0/0", occupancy, cdb_valid);
        end
        @(negedge clk);
        flush = 1'b0;
        rs_done = 3'b110;
        #1;
        checks++;
        if (issue_tag !== 4'd4 || rs_sel !== 3'b001 || rs_ack !== 3'b000) begin
            errors++;
            $display("FAIL flush_reissue tag=%0d sel=%b ack=%b exp 4/001/000",
                     issue_tag, rs_sel, rs_ack);
        end
        @(negedge clk);
        issue_valid = 1'b0;
        #1;
        checks++;
        if (rs_ack !== 3'b000) begin
            errors++;
            $display("FAIL flush_stale_done ack=%b exp 000", rs_ack);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cdb_valid !== 1'b0 || occupancy !== 4'd1) begin
            errors++;
            $display("FAIL flush_after v=%b occ=%0d exp 0/1", cdb_valid, occupancy);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        rs_done = 3'b000;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({occupancy, cdb_valid, cdb_tag, issue_tag} !== {4'd0, 1'b0, 4'd0, 4'd4}) begin
            errors++;
            $display("FAIL reset_mid occ=%0d v=%b tag=%0d itag=%0d exp 0/0/0/4",
                     occupancy, cdb_valid, cdb_tag, issue_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        issue_valid = 1'b0;
        rs_done = 3'b000;
        rs_result = {R2, R1, R0};
        cdb_ready = 1'b1;
        test_reset;
        test_issue;
        test_simultaneous;
        test_complete;
        test_backpressure;
        test_fairness;
        test_flush;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_rs_sched.md
# mul_rs_sched

Issue and completion controller for the multiply/divide reservation-station group in the Tomasulo core. It allocates free reservation-station entries to incoming mul/div instructions and drives each entry's one-hot `sel`. It hands out the entry's rename tag and keeps the entry reserved until its result has been broadcast. It arbitrates finished results round-robin into a registered valid/ready output stage feeding the common data bus (CDB).

## Interface
- NUM_RS, 3, number of mul/div reservation-station entries (2..8)
- TAG_BASE, 4, rename tag of entry 0; entry i owns tag TAG_BASE+i; TAG_BASE+NUM_RS-1 ≤ 15; tag 0 means "no producer"
- DATA_W, 32, result width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous squash of all entries and of the output stage
- issue_valid  in  1  decoder presents a mul/div instruction
- issue_ready  out  1  at least one entry free
- issue_tag  out  4  tag of the entry being allocated; 0 when issue_ready=0
- rs_sel  out  NUM_RS  one-hot entry select, per-entry `sel`
- rs_done  in  NUM_RS  entry i result valid; level, held until acked
- rs_result  in  NUM_RS*DATA_W  entry i result at bits [i*DATA_W +: DATA_W]
- rs_ack  out  NUM_RS  one-hot pulse: entry i result captured this edge
- cdb_valid  out  1  broadcast valid
- cdb_tag  out  4  broadcast tag
- cdb_data  out  DATA_W  broadcast value
- cdb_ready  in  1  CDB accepts broadcast this cycle
- occupancy  out  4  number of reserved entries

## Operation
- State: held[NUM_RS], rr_ptr (index), output register {cdb_valid, cdb_tag, cdb_data}.
- Allocation:
  - free[i] = !held[i].
  - issue_ready = |free.
  - Target = lowest-index free entry.
  - rs_sel = onehot(target) when issue_valid && issue_ready && !flush, else 0.
  - issue_tag = TAG_BASE+target when issue_ready, else 0.
  - An issue sets held[target] at the clock edge.
- Completion candidates: cand[i] = rs_done[i] && held[i]. rs_done on a non-held entry is ignored.
- Output stage loads when (!cdb_valid || cdb_ready) && |cand && !flush.
  - Winner = first candidate at or after rr_ptr, wrapping.
  - Load cdb_tag = TAG_BASE+winner and cdb_data = rs_result slice of the winner; set cdb_valid.
  - rs_ack[winner]=1 (combinational, same cycle).
  - Clear held[winner].
  - rr_ptr ← winner+1, wrapping to 0 after NUM_RS-1.
- When cdb_valid && cdb_ready and no new load, cdb_valid ← 0. cdb_tag and cdb_data hold their last values.
- While cdb_valid && !cdb_ready: cdb_tag and cdb_data stay stable, no ack is issued, and held bits do not clear.
- Simultaneous issue and ack:
  - They never hit the same entry, because the acked entry is still held this cycle.
  - A freed entry becomes allocatable the next cycle (no bypass).
- flush (priority over all but reset):
  - held ← 0, cdb_valid ← 0, rr_ptr ← 0.
  - rs_sel=0 and rs_ack=0 that cycle.
- occupancy = popcount(held), registered-state based.

## Timing
- Reset values: held=0, rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0, occupancy=0. This gives issue_ready=1, issue_tag=TAG_BASE, rs_sel=0, rs_ack=0.
- Reset mid-operation discards all held entries and any pending broadcast at the next edge.
- Issue is zero-latency combinational: sel goes to the entry in the same cycle as issue_valid, and the entry registers operands at that edge.
- Done-to-broadcast: rs_done[i] high in cycle N with a free output stage gives rs_ack[i] in cycle N and cdb_valid in N+1.
- Sustained throughput is 1 broadcast per cycle with cdb_ready=1.
- Full: issue_ready=0 for every cycle in which occupancy=NUM_RS. rs_sel must remain 0 even if issue_valid=1.
- Round-robin fairness: with all entries done continuously, each entry is granted once per NUM_RS grants.

## Test plan
- After reset, issue 3 instructions on consecutive cycles (NUM_RS=3, TAG_BASE=4):
  - rs_sel = 001, 010, 100.
  - issue_tag = 4, 5, 6.
  - Then issue_ready=0, issue_tag=0, occupancy=3.
  - A 4th issue_valid produces no sel.
- Entry 1 raises rs_done with 0x0000_00A5, cdb_ready=1:
  - rs_ack=010 the same cycle.
  - Next cycle cdb_valid=1, cdb_tag=5, cdb_data=0x0000_00A5.
  - Next cycle issue_ready=1, issue_tag=5.
- All 3 entries done simultaneously, cdb_ready=1, rr_ptr=0: broadcasts tags 4, 5, 6 on 3 consecutive cycles, with one ack per cycle.
- Backpressure: cdb_ready=0 for 4 cycles with cdb_valid=1:
  - cdb_tag and cdb_data stable.
  - No rs_ack.
  - When cdb_ready rises, the next candidate is loaded the same edge.
- Fairness: after a grant to entry 2, with entries 0 and 2 both continuously done, grants alternate 0, 2, 0, 2.
- flush asserted with 3 held entries and cdb_valid=1:
  - Next cycle occupancy=0 and cdb_valid=0.
  - The first issue afterwards gets tag 4.
  - rs_done on entries not re-issued is ignored.
